// File: rtl/rr_reg_arbiter_pkg.sv
// rtl/rr_reg_arbiter_pkg.sv - shared types and helpers for the round-robin register arbiter
// Purpose: FSM state encoding and an index-width helper shared by the
//          arbiter top, its priority picker and its bus interface.
// Ports:   none (package)
package rr_reg_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } st_t;

   // Width of an index into n items; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// rtl/rr_reg_arbiter_if.sv - requester-side bus of the round-robin register arbiter
// Purpose: bundles the requester handshake, write path and grant/status outputs.
// Ports (signals):
//   req[N_REQ]        requester i wants/keeps ownership
//   wr_en[N_REQ]      per-requester write strobe
//   wr_data[N_REQ*DW] requester i data in bits [i*DW +: DW]
//   gnt[N_REQ]        one-hot ownership grant
//   owner_id          index of current owner (valid while busy)
//   busy              a grant is held
//   timeout           one-cycle pulse when an owner is preempted
//   q[DW]             shared register contents
// Modports: master = requester side, slave = arbiter side.
interface rr_reg_arbiter_if
   import rr_reg_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DW    = 8
) ();

   localparam int IW = idx_w(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    wr_en;
   logic [N_REQ*DW-1:0] wr_data;
   logic [N_REQ-1:0]    gnt;
   logic [IW-1:0]       owner_id;
   logic                busy;
   logic                timeout;
   logic [DW-1:0]       q;

   modport master (
      output req, wr_en, wr_data,
      input  gnt, owner_id, busy, timeout, q
   );

   modport slave (
      input  req, wr_en, wr_data,
      output gnt, owner_id, busy, timeout, q
   );

endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// rtl/rr_reg_arbiter_pick.sv - rotating-priority first-one search
// Purpose: finds the first asserted request scanning ptr, ptr+1, ... (mod N_REQ).
// Ports:
//   req[N_REQ]  in   request vector
//   ptr         in   highest-priority index
//   found       out  at least one request is set
//   idx         out  index of the winning request (0 when none)
module rr_pick
   import rr_reg_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]          req,
   input  logic [idx_w(N_REQ)-1:0]   ptr,
   output logic                      found,
   output logic [idx_w(N_REQ)-1:0]   idx
);

   localparam int IW = idx_w(N_REQ);

   logic [IW:0] pos;

   // Scan from the lowest priority upward so the last hit written is the
   // highest-priority one.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N_REQ)) begin
            pos = pos - (IW+1)'(N_REQ);
         end
         if (req[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbitrated shared register with hold cap
// Purpose: grants one requester at a time exclusive write access to a DW-bit
//          register; ownership ends on release or after HOLD_MAX cycles.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of rr_reg_arbiter_if (req/wr_en/wr_data in,
//         gnt/owner_id/busy/timeout/q out)
module rr_reg_arbiter
   import rr_reg_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DW       = 8,
   parameter int HOLD_MAX = 4
) (
   input logic              clk,
   input logic              rst,
   rr_reg_arbiter_if.slave  bus
);

   localparam int              IW        = idx_w(N_REQ);
   localparam int              HW        = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_MAX - 1);
   localparam logic [IW-1:0]   LAST_IDX  = IW'(N_REQ - 1);

   st_t            st, st_n;
   logic [IW-1:0]  owner, owner_n;
   logic [IW-1:0]  ptr, ptr_n;
   logic [IW-1:0]  next_ptr;
   logic [HW-1:0]  hold, hold_n;
   logic           to_r, to_n;
   logic [DW-1:0]  q_r, q_n;
   logic           pick_found;
   logic [IW-1:0]  pick_idx;
   logic [DW-1:0]  wr_slice [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign wr_slice[g] = bus.wr_data[g*DW +: DW];
   end

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Priority moves just past the owner that is giving up the register.
   assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

   always_comb begin
      st_n    = st;
      owner_n = owner;
      ptr_n   = ptr;
      hold_n  = hold;
      to_n    = 1'b0;
      q_n     = q_r;
      case (st)
         ST_IDLE: begin
            if (pick_found) begin
               st_n    = ST_BUSY;
               owner_n = pick_idx;
               hold_n  = '0;
            end
         end
         ST_BUSY: begin
            if (!bus.req[owner]) begin
               // Release wins over a simultaneous timeout; its write is dropped.
               st_n  = ST_IDLE;
               ptr_n = next_ptr;
            end else begin
               if (bus.wr_en[owner]) begin
                  q_n = wr_slice[owner];
               end
               if (hold == HOLD_LAST) begin
                  st_n  = ST_IDLE;
                  ptr_n = next_ptr;
                  to_n  = 1'b1;
               end else begin
                  hold_n = hold + 1'b1;
               end
            end
         end
         default: st_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= ST_IDLE;
         owner <= '0;
         ptr   <= '0;
         hold  <= '0;
         to_r  <= 1'b0;
         q_r   <= '0;
      end else begin
         st    <= st_n;
         owner <= owner_n;
         ptr   <= ptr_n;
         hold  <= hold_n;
         to_r  <= to_n;
         q_r   <= q_n;
      end
   end

   // Grant is derived from state and owner so it is one-hot and zero in IDLE
   // by construction.
   assign bus.gnt      = (st == ST_BUSY) ? (N_REQ'(1) << owner) : '0;
   assign bus.busy     = (st == ST_BUSY);
   assign bus.owner_id = owner;
   assign bus.timeout  = to_r;
   assign bus.q        = q_r;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb/tb_rr_reg_arbiter.sv - self-checking bench for rr_reg_arbiter
module tb_rr_reg_arbiter;

   localparam int N_REQ    = 4;
   localparam int DW       = 8;
   localparam int HOLD_MAX = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rr_reg_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

   rr_reg_arbiter #(.N_REQ(N_REQ), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  wr_en;
      logic [31:0] wr_data;
      logic [3:0]  gnt;
      logic [1:0]  own;
      logic        to;
      logic [7:0]  q;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] own;
      logic       to;
      logic [7:0] q;
   } exp_t;

   exp_t sb[$];
   vec_t tbl_a[$];
   vec_t tbl_b[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] we,
                               input logic [31:0] wd, input logic [3:0] g,
                               input logic [1:0] o, input logic t, input logic [7:0] qq);
      vec_t v;
      v.rst = r; v.req = rq; v.wr_en = we; v.wr_data = wd;
      v.gnt = g; v.own = o; v.to = t; v.q = qq;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input string name, input vec_t v);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst         = v.rst;
      bus.req     = v.req;
      bus.wr_en   = v.wr_en;
      bus.wr_data = v.wr_data;
      e.gnt = v.gnt; e.own = v.own; e.to = v.to; e.q = v.q;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s.scoreboard: got empty expected entry", name);
      end else begin
         got = sb.pop_front();
         chk({name, ".gnt"},     32'(bus.gnt),     32'(got.gnt));
         chk({name, ".busy"},    32'(bus.busy),    32'(|got.gnt));
         chk({name, ".timeout"}, 32'(bus.timeout), 32'(got.to));
         chk({name, ".q"},       32'(bus.q),       32'(got.q));
         if (|got.gnt) begin
            chk({name, ".owner"}, 32'(bus.owner_id), 32'(got.own));
         end
      end
   endtask

   initial begin
      vec_t v;
      logic [7:0] exp_q;

      rst = 1'b1; bus.req = '0; bus.wr_en = '0; bus.wr_data = '0;

      // owner 2 write path, foreign strobe ignored, release drops its write
      tbl_a.push_back(mk(0, 4'b0100, 4'b0000, 32'h0000_0000, 4'b0100, 2, 0, 8'h00));
      tbl_a.push_back(mk(0, 4'b0100, 4'b0100, 32'h00A5_0000, 4'b0100, 2, 0, 8'hA5));
      tbl_a.push_back(mk(0, 4'b0100, 4'b0101, 32'h0011_00FF, 4'b0100, 2, 0, 8'h11));
      tbl_a.push_back(mk(0, 4'b0000, 4'b0100, 32'h0022_0000, 4'b0000, 0, 0, 8'h11));
      tbl_a.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 8'h11));

      // owner 3 release with ptr wrap, reset mid-BUSY, release at the hold limit
      tbl_b.push_back(mk(0, 4'b1000, 4'b0000, 32'h0000_0000, 4'b1000, 3, 0, 8'hC0));
      tbl_b.push_back(mk(0, 4'b0011, 4'b1000, 32'h7700_0000, 4'b0000, 0, 0, 8'hC0));
      tbl_b.push_back(mk(0, 4'b0011, 4'b0000, 32'h0000_0000, 4'b0001, 0, 0, 8'hC0));
      tbl_b.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 8'hC0));
      tbl_b.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_0000, 4'b0010, 1, 0, 8'hC0));
      tbl_b.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_5A00, 4'b0010, 1, 0, 8'h5A));
      tbl_b.push_back(mk(1, 4'b0010, 4'b0010, 32'h0000_9900, 4'b0000, 0, 0, 8'h00));
      tbl_b.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 0, 0, 8'h00));
      tbl_b.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_0033, 4'b0001, 0, 0, 8'h33));
      tbl_b.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 0, 0, 8'h33));
      tbl_b.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 0, 0, 8'h33));
      tbl_b.push_back(mk(0, 4'b0000, 4'b0001, 32'h0000_0044, 4'b0000, 0, 0, 8'h33));
      tbl_b.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 8'h33));

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         v = mk(1, 4'($urandom), 4'($urandom), $urandom, 4'b0000, 0, 0, 8'h00);
         step($sformatf("reset%0d", i), v);
      end

      for (int i = 0; i < tbl_a.size(); i++) begin
         step($sformatf("vec_a%0d", i), tbl_a[i]);
      end

      step("rst_pre_rr", mk(1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00));

      // all requesting: owners 0,1,2,3,0, four grant cycles then a timeout idle
      exp_q = 8'h00;
      for (int blk = 0; blk < 5; blk++) begin
         int o;
         o = blk % 4;
         for (int c = 0; c < 5; c++) begin
            if (c >= 1) exp_q = 8'hC0 + 8'(o);
            v = mk(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0,
                   (c < 4) ? 4'(1 << o) : 4'b0000, 2'(o), (c == 4), exp_q);
            step($sformatf("rr_b%0d_c%0d", blk, c), v);
         end
      end

      for (int i = 0; i < tbl_b.size(); i++) begin
         step($sformatf("vec_b%0d", i), tbl_b[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
